// File: rtl/cla_add_sequencer.sv
// cla_add_sequencer: multi-cycle WIDTH-bit add/subtract using one shared
// 8-bit carry-lookahead slice, one slice per cycle from LSB to MSB.
// Ports: clock, reset (sync, active-high), start, ctrl_ALUopcode[4:0],
//   data_operandA/B[WIDTH-1:0] in; data_result, overflow, carry_out,
//   isNotEqual, isLessThan, busy, data_resultRDY out.

module cla_block (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    input  logic       pin,
    input  logic       gin,
    output logic [7:0] s,
    output logic       cout,
    output logic       pout,
    output logic       gout
);
    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;
    logic       gg;
    logic       pp;

    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
            gg     = g[i] | (p[i] & gg);
            pp     = pp & p[i];
        end
        s    = p ^ c[7:0];
        // carry into bit 7, used for signed overflow detection
        cout = c[7];
        // gin merges a lower group's generate; pin kills group propagate
        gout = gg | (pp & gin);
        pout = pp & ~pin;
    end
endmodule

module cla_add_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow,
    output logic             carry_out,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             busy,
    output logic             data_resultRDY
);
    localparam int N  = WIDTH / 8;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             sub_q, sub_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             ovf_q, ovf_d;
    logic             co_q, co_d;
    logic             ne_q, ne_d;
    logic             lt_q, lt_d;

    logic [IW+2:0]    base;
    logic [7:0]       sl_a;
    logic [7:0]       sl_b;
    logic [7:0]       sl_s;
    logic             sl_c7;
    logic             sl_p;
    logic             sl_g;
    logic             sl_c8;
    logic             legal;
    logic             last;

    assign base  = {idx_q, 3'b000};
    assign sl_a  = a_q[base +: 8];
    assign sl_b  = b_q[base +: 8];
    assign sl_c8 = sl_g | (sl_p & carry_q);
    assign legal = (ctrl_ALUopcode == 5'b00000) ||
                   (ctrl_ALUopcode == 5'b00001);
    assign last  = (idx_q == IW'(N - 1));

    cla_block u_slice (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry_q),
        .pin  (1'b0),
        .gin  (1'b0),
        .s    (sl_s),
        .cout (sl_c7),
        .pout (sl_p),
        .gout (sl_g)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sub_d   = sub_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        co_d    = co_q;
        ne_d    = ne_q;
        lt_d    = lt_q;
        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start && legal) begin
                    // subtract is A + ~B + 1: invert B, seed carry with 1
                    sub_d   = ctrl_ALUopcode[0];
                    a_d     = data_operandA;
                    b_d     = ctrl_ALUopcode[0] ? ~data_operandB
                                                : data_operandB;
                    carry_d = ctrl_ALUopcode[0];
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                res_d[base +: 8] = sl_s;
                carry_d          = sl_c8;
                if (last) begin
                    ovf_d   = sl_c7 ^ sl_c8;
                    co_d    = sl_c8;
                    ne_d    = |res_d;
                    lt_d    = sub_q & (res_d[WIDTH-1] ^ ovf_d);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sub_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            co_q    <= 1'b0;
            ne_q    <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sub_q   <= sub_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            co_q    <= co_d;
            ne_q    <= ne_d;
            lt_q    <= lt_d;
        end
    end

    assign data_result    = res_q;
    assign overflow       = ovf_q;
    assign carry_out      = co_q;
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign busy           = (state_q == RUN);
    assign data_resultRDY = (state_q == DONE);
endmodule

// File: tb/tb_cla_add_sequencer.sv
// tb_cla_add_sequencer: scoreboard bench for cla_add_sequencer.
// Arithmetic reference model, queue of expected results, negedge monitor.

module tb_cla_add_sequencer;
    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data_result;
    logic        overflow;
    logic        carry_out;
    logic        isNotEqual;
    logic        isLessThan;
    logic        busy;
    logic        data_resultRDY;

    cla_add_sequencer #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .start          (start),
        .ctrl_ALUopcode (op),
        .data_operandA  (a),
        .data_operandB  (b),
        .data_result    (data_result),
        .overflow       (overflow),
        .carry_out      (carry_out),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .busy           (busy),
        .data_resultRDY (data_resultRDY)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        ovf;
        logic        co;
        logic        ne;
        logic        lt;
        int          due;
    } exp_t;

    exp_t sbq[$];
    exp_t last = '{res: 0, ovf: 0, co: 0, ne: 0, lt: 0, due: 0};
    int   errors = 0;
    int   checks = 0;
    int   last_acc = -100;
    int   busy_until = 0;
    bit   mon_en = 0;

    function automatic exp_t model(input logic [4:0] o,
                                   input logic [31:0] x,
                                   input logic [31:0] y,
                                   input int due);
        exp_t   e;
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint r;
        longint unsigned ux = x;
        longint unsigned uy = y;
        longint unsigned us;
        if (o == 5'd1) begin
            r     = sx - sy;
            e.res = x - y;
            e.co  = (x >= y);
            e.lt  = (sx < sy);
        end else begin
            r     = sx + sy;
            us    = ux + uy;
            e.res = x + y;
            e.co  = us[32];
            e.lt  = 1'b0;
        end
        e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        e.ne  = (e.res != 0);
        e.due = due;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            logic eb;
            logic er;
            eb = (cyc > last_acc) && (cyc < last_acc + 5);
            er = (sbq.size() > 0) && (sbq[0].due == cyc);
            chk("busy", 32'(busy), 32'(eb));
            chk("rdy", 32'(data_resultRDY), 32'(er));
            if (data_resultRDY && er) begin
                exp_t e;
                e = sbq.pop_front();
                chk("result", data_result, e.res);
                chk("overflow", 32'(overflow), 32'(e.ovf));
                chk("carry_out", 32'(carry_out), 32'(e.co));
                chk("isNotEqual", 32'(isNotEqual), 32'(e.ne));
                chk("isLessThan", 32'(isLessThan), 32'(e.lt));
                last = e;
            end else if (!busy && !data_resultRDY) begin
                chk("hold_result", data_result, last.res);
                chk("hold_flags",
                    32'({overflow, carry_out, isNotEqual, isLessThan}),
                    32'({last.ovf, last.co, last.ne, last.lt}));
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic issue(input logic [4:0] o, input logic [31:0] x,
                         input logic [31:0] y);
        @(negedge clock);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if ((o == 5'd0 || o == 5'd1) && cyc >= busy_until) begin
            sbq.push_back(model(o, x, y, cyc + 5));
            last_acc   = cyc;
            busy_until = cyc + 5;
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        op    = 5'($urandom);
        a     = $urandom;
        b     = $urandom;
    endtask

    function automatic logic [31:0] pick();
        unique case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        wait_cyc(3);
        chk("rst_result", data_result, 32'h0);
        chk("rst_flags",
            32'({overflow, carry_out, isNotEqual, isLessThan}), 32'h0);
        chk("rst_busy_rdy", 32'({busy, data_resultRDY}), 32'h0);
        reset      = 1'b0;
        busy_until = cyc;
        mon_en     = 1'b1;

        issue(5'd0, 32'h0000_00FF, 32'h0000_0001);
        wait_cyc(6);
        issue(5'd0, 32'h7FFF_FFFF, 32'h0000_0001);
        wait_cyc(6);
        issue(5'd0, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_cyc(6);
        issue(5'd1, 32'd5, 32'd7);
        wait_cyc(6);
        issue(5'd1, 32'h8000_0000, 32'd1);
        wait_cyc(6);
        issue(5'd1, 32'd9, 32'd9);
        wait_cyc(6);

        issue(5'd0, 32'h1234_5678, 32'h1111_1111);
        wait_cyc(1);
        issue(5'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_cyc(2);
        issue(5'd1, 32'h0000_0010, 32'h0000_0020);
        wait_cyc(7);

        issue(5'd0, 32'hAAAA_AAAA, 32'h5555_5555);
        wait_cyc(1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        sbq.delete();
        last       = '{res: 0, ovf: 0, co: 0, ne: 0, lt: 0, due: 0};
        last_acc   = -100;
        busy_until = cyc;
        @(negedge clock);
        chk("midrst_result", data_result, 32'h0);
        chk("midrst_flags",
            32'({overflow, carry_out, isNotEqual, isLessThan}), 32'h0);
        chk("midrst_busy_rdy", 32'({busy, data_resultRDY}), 32'h0);
        reset = 1'b0;
        issue(5'd0, 32'd3, 32'd4);
        wait_cyc(6);

        issue(5'd2, 32'd1, 32'd2);
        wait_cyc(10);

        for (int i = 0; i < 60; i++) begin
            logic [4:0] o;
            if ($urandom_range(0, 9) == 0)
                o = 5'($urandom_range(2, 31));
            else
                o = 5'($urandom_range(0, 1));
            issue(o, pick(), pick());
            wait_cyc($urandom_range(0, 6));
        end

        for (int i = 0; i < 20; i++) begin
            if (sbq.size() == 0) break;
            @(negedge clock);
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
